// File: rtl/tis_core.sv
// tis_core: one execution node of a TIS-style grid processor.
// Runs up to 15 instructions, saturating ACC/BAK, four blocking one-word neighbour ports.
module tis_core (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        pLength,
   input  logic [14:0][15:0] prog,
   output logic [10:0]       acc,
   output logic [3:0]        write,
   input  logic [3:0]        wready,
   output logic [10:0]       out,
   input  logic              rreadyU,
   input  logic              rreadyR,
   input  logic              rreadyD,
   input  logic              rreadyL,
   output logic              readU,
   output logic              readR,
   output logic              readD,
   output logic              readL,
   input  logic [10:0]       up,
   input  logic [10:0]       right,
   input  logic [10:0]       down,
   input  logic [10:0]       left
);

   localparam int unsigned DW = 11;
   localparam int unsigned PW = 4;
   localparam int unsigned XW = 13;

   localparam logic [0:0] ST_EXEC  = 1'b0;
   localparam logic [0:0] ST_WRITE = 1'b1;

   localparam logic signed [DW-1:0] ACC_MAX = 11'sd999;
   localparam logic signed [DW-1:0] ACC_MIN = -11'sd999;

   localparam logic [3:0] OP_MOV = 4'd1;
   localparam logic [3:0] OP_SWP = 4'd2;
   localparam logic [3:0] OP_SAV = 4'd3;
   localparam logic [3:0] OP_ADD = 4'd4;
   localparam logic [3:0] OP_SUB = 4'd5;
   localparam logic [3:0] OP_NEG = 4'd6;
   localparam logic [3:0] OP_JMP = 4'd7;
   localparam logic [3:0] OP_JEZ = 4'd8;
   localparam logic [3:0] OP_JNZ = 4'd9;
   localparam logic [3:0] OP_JGZ = 4'd10;
   localparam logic [3:0] OP_JLZ = 4'd11;
   localparam logic [3:0] OP_JRO = 4'd12;

   localparam logic [2:0] LOC_ACC = 3'd5;

   logic [0:0]           r_state, w_state_nxt;
   logic [PW-1:0]        r_pc, w_pc_nxt;
   logic signed [DW-1:0] r_acc, w_acc_nxt;
   logic signed [DW-1:0] r_bak, w_bak_nxt;
   logic [3:0]           r_write, w_write_nxt;
   logic [DW-1:0]        r_out, w_out_nxt;

   // Clamp a widened result into the ACC range.
   function automatic logic signed [DW-1:0] f_sat(input logic signed [XW-1:0] v);
      if (v > 13'sd999) return ACC_MAX;
      if (v < -13'sd999) return ACC_MIN;
      return DW'(v);
   endfunction

   // Pad the program to 16 words so every PC value indexes a defined word.
   logic [15:0][15:0] w_prog;
   logic [15:0]       w_ins;
   assign w_prog = {16'h0000, prog};
   assign w_ins  = w_prog[r_pc];

   logic                 w_is_movi, w_is_alui, w_is_reg;
   logic [3:0]           w_op, w_tgt, w_rready;
   logic [2:0]           w_iop, w_src, w_dst, w_wdst;
   logic signed [DW-1:0] w_imm;

   assign w_is_movi = (w_ins[15:14] == 2'b11);
   assign w_is_alui = (w_ins[15:14] == 2'b10);
   assign w_is_reg  = ~w_ins[15];
   assign w_op      = w_ins[13:10];
   assign w_iop     = w_ins[13:11];
   assign w_src     = w_ins[9:7];
   assign w_dst     = w_ins[6:4];
   assign w_tgt     = w_ins[3:0];
   assign w_imm     = w_ins[10:0];
   assign w_rready  = {rreadyL, rreadyD, rreadyR, rreadyU};

   logic w_uses_src, w_src_port, w_stall, w_active, w_to_port;
   logic [3:0] w_read;

   assign w_uses_src = w_is_reg && ((w_op == OP_MOV) || (w_op == OP_ADD) ||
                                    (w_op == OP_SUB) || (w_op == OP_JRO));
   assign w_src_port = w_uses_src && !w_src[2];
   assign w_stall    = w_src_port && !w_rready[w_src[1:0]];
   assign w_active   = !rst && (r_state == ST_EXEC) && (pLength != 4'd0);
   assign w_read     = (w_active && w_src_port) ? (w_rready & (4'b0001 << w_src[1:0])) : 4'b0000;
   assign w_wdst     = w_is_movi ? w_iop : w_dst;
   assign w_to_port  = (w_is_movi || (w_is_reg && (w_op == OP_MOV))) && !w_wdst[2];

   assign readU = w_read[0];
   assign readR = w_read[1];
   assign readD = w_read[2];
   assign readL = w_read[3];

   logic signed [DW-1:0] w_src_val;
   always_comb begin
      w_src_val = '0;
      case (w_src)
         3'd0:    w_src_val = up;
         3'd1:    w_src_val = right;
         3'd2:    w_src_val = down;
         3'd3:    w_src_val = left;
         LOC_ACC: w_src_val = r_acc;
         default: w_src_val = '0;
      endcase
   end

   logic signed [DW-1:0] w_val, w_opnd;
   logic signed [XW-1:0] w_sum, w_dif, w_pc_ext, w_last, w_jro_sum;
   logic [PW-1:0]        w_pc_inc, w_pc_jmp, w_pc_jro;

   assign w_val     = w_is_movi ? f_sat(XW'(w_imm)) : w_src_val;
   assign w_opnd    = w_is_alui ? w_imm : w_src_val;
   assign w_sum     = XW'(r_acc) + XW'(w_opnd);
   assign w_dif     = XW'(r_acc) - XW'(w_opnd);
   assign w_pc_inc  = (r_pc >= pLength - 4'd1) ? 4'd0 : r_pc + 4'd1;
   assign w_pc_jmp  = (w_tgt >= pLength) ? 4'd0 : w_tgt;
   assign w_pc_ext  = {9'd0, r_pc};
   assign w_last    = {9'd0, pLength - 4'd1};
   assign w_jro_sum = w_pc_ext + XW'(w_opnd);
   assign w_pc_jro  = (w_jro_sum < 13'sd0) ? 4'd0 :
                      (w_jro_sum > w_last) ? w_last[PW-1:0] : w_jro_sum[PW-1:0];

   // Next-state logic: execute phase or pending-write phase.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_acc_nxt   = r_acc;
      w_bak_nxt   = r_bak;
      w_write_nxt = r_write;
      w_out_nxt   = r_out;
      case (r_state)
         ST_EXEC: begin
            if (w_active && !w_stall) begin
               if (w_to_port) begin
                  w_out_nxt   = w_val;
                  w_write_nxt = 4'b0001 << w_wdst[1:0];
                  w_state_nxt = ST_WRITE;
               end else begin
                  w_pc_nxt = w_pc_inc;
                  if (w_is_movi) begin
                     if (w_wdst == LOC_ACC) w_acc_nxt = w_val;
                  end else if (w_is_alui) begin
                     case (w_iop)
                        3'd0:    w_acc_nxt = f_sat(w_sum);
                        3'd1:    w_acc_nxt = f_sat(w_dif);
                        3'd2:    w_pc_nxt  = w_pc_jro;
                        default: ;
                     endcase
                  end else begin
                     case (w_op)
                        OP_MOV: if (w_dst == LOC_ACC) w_acc_nxt = f_sat(XW'(w_src_val));
                        OP_SWP: begin
                           w_acc_nxt = r_bak;
                           w_bak_nxt = r_acc;
                        end
                        OP_SAV: w_bak_nxt = r_acc;
                        OP_ADD: w_acc_nxt = f_sat(w_sum);
                        OP_SUB: w_acc_nxt = f_sat(w_dif);
                        OP_NEG: w_acc_nxt = -r_acc;
                        OP_JMP: w_pc_nxt  = w_pc_jmp;
                        OP_JEZ: if (r_acc == 11'sd0) w_pc_nxt = w_pc_jmp;
                        OP_JNZ: if (r_acc != 11'sd0) w_pc_nxt = w_pc_jmp;
                        OP_JGZ: if (r_acc > 11'sd0)  w_pc_nxt = w_pc_jmp;
                        OP_JLZ: if (r_acc < 11'sd0)  w_pc_nxt = w_pc_jmp;
                        OP_JRO: w_pc_nxt  = w_pc_jro;
                        default: ;
                     endcase
                  end
               end
            end
         end
         ST_WRITE: begin
            if ((r_write & wready) != 4'b0000) begin
               w_write_nxt = 4'b0000;
               w_pc_nxt    = w_pc_inc;
               w_state_nxt = ST_EXEC;
            end
         end
         default: w_state_nxt = ST_EXEC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_EXEC;
         r_pc    <= '0;
         r_acc   <= '0;
         r_bak   <= '0;
         r_write <= '0;
         r_out   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_acc   <= w_acc_nxt;
         r_bak   <= w_bak_nxt;
         r_write <= w_write_nxt;
         r_out   <= w_out_nxt;
      end
   end

   assign acc   = r_acc;
   assign write = r_write;
   assign out   = r_out;

endmodule

// File: tb/tb_tis_core.sv
// Self-checking bench for tis_core: single-node programs plus a two-node link.
// Expected ACC values are queued up front and popped as the node produces them.
module tb_tis_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              link;
   logic [3:0]        p0_len, p1_len;
   logic [14:0][15:0] p0_prog, p1_prog;
   logic [10:0]       acc0, acc1, out0, out1;
   logic [3:0]        wr0, wr1, wready0, tb_wready;
   logic              tb_rU, tb_rR, tb_rD, tb_rL;
   logic [10:0]       tb_up, tb_right, tb_down, tb_left;
   logic              rdU0, rdR0, rdD0, rdL0, rdU1, rdR1, rdD1, rdL1;

   int n_cmp = 0;
   int n_err = 0;
   int exp_q[$];

   assign wready0 = link ? {2'b00, rdL1, 1'b0} : tb_wready;

   tis_core u_n0 (
      .clk(clk), .rst(rst), .pLength(p0_len), .prog(p0_prog),
      .acc(acc0), .write(wr0), .wready(wready0), .out(out0),
      .rreadyU(tb_rU), .rreadyR(tb_rR), .rreadyD(tb_rD), .rreadyL(tb_rL),
      .readU(rdU0), .readR(rdR0), .readD(rdD0), .readL(rdL0),
      .up(tb_up), .right(tb_right), .down(tb_down), .left(tb_left)
   );

   tis_core u_n1 (
      .clk(clk), .rst(rst), .pLength(p1_len), .prog(p1_prog),
      .acc(acc1), .write(wr1), .wready(4'b0000), .out(out1),
      .rreadyU(1'b0), .rreadyR(1'b0), .rreadyD(1'b0), .rreadyL(link & wr0[1]),
      .readU(rdU1), .readR(rdR1), .readD(rdD1), .readL(rdL1),
      .up(11'd0), .right(11'd0), .down(11'd0), .left(out0)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] alui(input int op, input int imm);
      return {2'b10, 3'(op), 11'(imm)};
   endfunction

   function automatic logic [15:0] movi(input int dst, input int imm);
      return {2'b11, 3'(dst), 11'(imm)};
   endfunction

   function automatic logic [15:0] rop(input int op, input int src, input int dst, input int tgt);
      return {2'b00, 4'(op), 3'(src), 3'(dst), 4'(tgt)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Pop one expected ACC per cycle and compare against node 0.
   task automatic run_seq(input string tag, input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         tick();
         if (exp_q.size() != 0) chk(tag, int'($signed(acc0)), exp_q.pop_front());
      end
      chk({tag, "_drain"}, exp_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; link = 1'b0;
      p0_len = 4'd0; p1_len = 4'd0; p0_prog = '0; p1_prog = '0;
      tb_wready = 4'b0000;
      tb_rU = 1'b0; tb_rR = 1'b0; tb_rD = 1'b0; tb_rL = 1'b0;
      tb_up = 11'd0; tb_right = 11'd0; tb_down = 11'd0; tb_left = 11'd0;

      // Reset state, then first executed instruction must be word 0
      p0_prog[0] = rop(4, 0, 0, 0);
      p0_prog[1] = alui(0, 100);
      p0_len = 4'd2; tb_rU = 1'b1; tb_up = 11'd5;
      do_reset();
      chk("rst_acc", int'(acc0), 0);
      chk("rst_write", int'(wr0), 0);
      chk("rst_out", int'(out0), 0);
      rst = 1'b1; #1;
      chk("rst_read", int'({rdU0, rdR0, rdD0, rdL0}), 0);
      rst = 1'b0;
      tick();
      chk("rst_pc0", int'($signed(acc0)), 5);
      tb_rU = 1'b0;

      // Immediate ALU with saturation at both ends and wrap
      p0_prog = '0;
      p0_prog[0] = alui(0, 600);
      p0_prog[1] = alui(0, 600);
      p0_prog[2] = alui(1, 1000);
      p0_prog[3] = alui(1, 1000);
      p0_prog[4] = rop(6, 0, 0, 0);
      p0_len = 4'd5;
      do_reset();
      exp_q = '{600, 999, -1, -999, 999, 999, 999, -1};
      run_seq("alu", 8);

      // Conditional jump skips word 2; SWP round trip through BAK
      p0_prog = '0;
      p0_prog[0] = alui(0, 1);
      p0_prog[1] = rop(9, 0, 0, 3);
      p0_prog[2] = alui(0, 500);
      p0_prog[3] = rop(2, 0, 0, 0);
      p0_len = 4'd4;
      do_reset();
      exp_q = '{1, 1, 0, 1, 1, 1, 2};
      run_seq("jmp", 7);

      // MOV immediate clamp, JLZ, jump target beyond pLength
      p0_prog = '0;
      p0_prog[0] = movi(5, 1023);
      p0_prog[1] = movi(5, -1024);
      p0_prog[2] = rop(11, 0, 0, 3);
      p0_prog[3] = rop(7, 0, 0, 9);
      p0_len = 4'd4;
      do_reset();
      exp_q = '{999, -999, -999, -999, 999, -999};
      run_seq("clamp", 6);

      // JRO clamped at both ends
      p0_prog = '0;
      p0_prog[0] = alui(0, 10);
      p0_prog[1] = alui(2, 100);
      p0_prog[2] = alui(0, 500);
      p0_prog[3] = alui(0, 500);
      p0_prog[4] = alui(2, -100);
      p0_len = 4'd5;
      do_reset();
      exp_q = '{10, 10, 10, 20, 20, 20, 30};
      run_seq("jro", 7);

      // Idle node: no execution and no port activity
      p0_prog = '0;
      p0_prog[0] = rop(4, 0, 0, 0);
      p0_len = 4'd0; tb_rU = 1'b1; tb_up = 11'd9;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle_read", int'(rdU0), 0);
         chk("idle_acc", int'(acc0), 0);
      end
      chk("idle_write", int'(wr0), 0);
      tb_rU = 1'b0;

      // Stall on LEFT, then a single-cycle read
      p0_prog = '0;
      p0_prog[0] = rop(4, 3, 0, 0);
      p0_len = 4'd1; tb_left = 11'd123;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("stall_acc", int'(acc0), 0);
         chk("stall_read", int'(rdL0), 0);
      end
      tb_rL = 1'b1; #1;
      chk("stall_read_hi", int'(rdL0), 1);
      tick();
      chk("stall_acc_got", int'($signed(acc0)), 123);
      tb_rL = 1'b0; #1;
      chk("stall_read_lo", int'(rdL0), 0);
      tick();
      chk("stall_acc_hold", int'($signed(acc0)), 123);

      // MOV port to port: read phase then write phase
      p0_prog = '0;
      p0_prog[0] = rop(1, 0, 3, 0);
      p0_len = 4'd1; tb_rU = 1'b1; tb_up = 11'd77;
      do_reset();
      #1;
      chk("p2p_read", int'(rdU0), 1);
      tick();
      chk("p2p_write", int'(wr0), 8);
      chk("p2p_out", int'(out0), 77);
      chk("p2p_read_done", int'(rdU0), 0);
      tb_rU = 1'b0;
      tick();
      chk("p2p_hold", int'(wr0), 8);
      tb_wready = 4'b1000;
      tick();
      chk("p2p_clear", int'(wr0), 0);
      tb_wready = 4'b0000;

      // Write handshake, foreign wready bits, reset during pending write
      p0_prog = '0;
      p0_prog[0] = movi(1, 5);
      p0_prog[1] = movi(2, 9);
      p0_len = 4'd2;
      do_reset();
      tick();
      chk("mw_write0", int'(wr0), 2);
      chk("mw_out0", int'(out0), 5);
      tb_wready = 4'b0010;
      tick();
      chk("mw_taken", int'(wr0), 0);
      tb_wready = 4'b0000;
      tick();
      chk("mw_write1", int'(wr0), 4);
      chk("mw_out1", int'(out0), 9);
      tb_wready = 4'b1011;
      tick();
      chk("mw_other_bits", int'(wr0), 4);
      rst = 1'b1;
      tick();
      chk("mw_rst_write", int'(wr0), 0);
      chk("mw_rst_out", int'(out0), 0);
      rst = 1'b0; tb_wready = 4'b0000;
      tick();
      chk("mw_restart", int'(wr0), 2);
      chk("mw_restart_out", int'(out0), 5);

      // Two-node link: node1 accumulates what node0 sends RIGHT
      p0_prog = '0;
      p0_prog[0] = movi(1, 5);
      p0_prog[1] = movi(1, -7);
      p0_len = 4'd2;
      p1_prog = '0;
      p1_prog[0] = rop(4, 3, 0, 0);
      p1_len = 4'd1;
      link = 1'b1;
      do_reset();
      exp_q = '{5, -2, 3, -4};
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
         logic took;
         took = rdL1;
         tick();
         if (took) chk("link_acc", int'($signed(acc1)), exp_q.pop_front());
      end
      chk("link_drain", exp_q.size(), 0);
      link = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
